// File: rtl/pa_fpu.sv
// pa_fpu: shared FPU types and constants.
//   e_fpu_operation : 4-bit opcode set understood by the arithmetic core
//   e_fpuif_state   : CPU bus front-end sequencing states
//   ADDR_*          : CPU-visible register addresses of fpu_bus_if
//   op_is_valid()   : opcode range check used before issuing to the core
package pa_fpu;

    typedef enum logic [3:0] {
        op_add     = 4'h0,
        op_sub     = 4'h1,
        op_mul     = 4'h2,
        op_div     = 4'h3,
        op_sqrt    = 4'h4,
        op_sin     = 4'h5,
        op_cos     = 4'h6,
        op_tan     = 4'h7,
        op_log     = 4'h8,
        op_exp     = 4'h9,
        op_k_pi    = 4'hA,
        op_k_piby2 = 4'hB
    } e_fpu_operation;

    typedef enum logic [1:0] {
        if_idle_st,
        if_issue_st,
        if_busy_st,
        if_done_st
    } e_fpuif_state;

    localparam logic [3:0] ADDR_A0     = 4'h0;
    localparam logic [3:0] ADDR_B0     = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;
    localparam logic [3:0] ADDR_CMD    = 4'h9;
    localparam logic [3:0] ADDR_STATUS = 4'hA;
    localparam logic [3:0] ADDR_R0     = 4'hC;

    function automatic logic op_is_valid(input logic [3:0] code);
        return code <= 4'(op_k_piby2);
    endfunction

endpackage

// File: rtl/fpu_bus_if.sv
// fpu_bus_if: CPU-side front end of the Sol-1 FPU.
//   Byte-wide register interface (operands A/B, CTRL, CMD, STATUS, result)
//   on the 8-bit CPU bus; issues operations to the arithmetic core with a
//   start pulse, waits for core_done, captures the result and acks it.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   cpu_addr/wr/rd/wdata, cpu_rdata   CPU bus; read data registered
//   irq                               level interrupt: done & CTRL.ie
//   core_start/op/a/b                 issue side toward the core
//   core_done/result, core_ack        completion handshake from the core
module fpu_bus_if
    import pa_fpu::*;
#(
    parameter logic IRQ_ON_DONE = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     cpu_addr,
    input  logic           cpu_wr,
    input  logic           cpu_rd,
    input  logic [7:0]     cpu_wdata,
    output logic [7:0]     cpu_rdata,
    output logic           irq,
    output logic           core_start,
    output e_fpu_operation core_op,
    output logic [31:0]    core_a,
    output logic [31:0]    core_b,
    input  logic           core_done,
    input  logic [31:0]    core_result,
    output logic           core_ack
);

    e_fpuif_state state, state_next;

    logic [31:0] a_reg, b_reg, res_reg;
    logic [3:0]  op_reg;
    logic        ie_reg;
    logic        err_reg;
    logic        busy, done;
    logic        wr_a, wr_b, wr_ctrl, wr_cmd, wr_status;
    logic        blocked, issue_ok, bad_op, capture;
    logic [7:0]  rd_mux;

    // busy/done are views of the state; only err needs its own flop.
    assign busy = (state == if_issue_st) || (state == if_busy_st);
    assign done = (state == if_done_st);

    assign wr_a      = cpu_wr && (cpu_addr[3:2] == ADDR_A0[3:2]);
    assign wr_b      = cpu_wr && (cpu_addr[3:2] == ADDR_B0[3:2]);
    assign wr_ctrl   = cpu_wr && (cpu_addr == ADDR_CTRL);
    assign wr_cmd    = cpu_wr && (cpu_addr == ADDR_CMD);
    assign wr_status = cpu_wr && (cpu_addr == ADDR_STATUS);

    assign blocked  = busy && (wr_a || wr_b || wr_ctrl || wr_cmd);
    assign issue_ok = wr_cmd && !busy && op_is_valid(op_reg);
    assign bad_op   = wr_cmd && !busy && !op_is_valid(op_reg);
    assign capture  = (state == if_busy_st) && core_done;

    // Operand byte lanes; writes are frozen while an operation is in flight.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] a_q, b_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                a_q <= '0;
                b_q <= '0;
            end else if (!busy) begin
                if (wr_a && (cpu_addr[1:0] == 2'(i))) a_q <= cpu_wdata;
                if (wr_b && (cpu_addr[1:0] == 2'(i))) b_q <= cpu_wdata;
            end
        end

        assign a_reg[8*i +: 8] = a_q;
        assign b_reg[8*i +: 8] = b_q;
    end

    always_comb begin
        state_next = state;
        case (state)
            if_idle_st:  if (issue_ok) state_next = if_issue_st;
            if_issue_st: state_next = if_busy_st;
            if_busy_st:  if (core_done) state_next = if_done_st;
            if_done_st: begin
                if (issue_ok)
                    state_next = if_issue_st;
                else if (wr_status && cpu_wdata[1])
                    state_next = if_idle_st;
            end
            default:     state_next = if_idle_st;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (cpu_addr[3:2])
            ADDR_A0[3:2]: rd_mux = a_reg[8*cpu_addr[1:0] +: 8];
            ADDR_B0[3:2]: rd_mux = b_reg[8*cpu_addr[1:0] +: 8];
            ADDR_R0[3:2]: rd_mux = res_reg[8*cpu_addr[1:0] +: 8];
            default: begin
                if (cpu_addr == ADDR_CTRL)
                    rd_mux = {ie_reg, 3'b000, op_reg};
                else if (cpu_addr == ADDR_STATUS)
                    rd_mux = {5'b00000, err_reg, done, busy};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= if_idle_st;
            op_reg    <= '0;
            ie_reg    <= 1'b0;
            err_reg   <= 1'b0;
            res_reg   <= '0;
            core_ack  <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            state    <= state_next;
            core_ack <= capture;
            if (capture)
                res_reg <= core_result;
            if (wr_ctrl && !busy) begin
                op_reg <= cpu_wdata[3:0];
                ie_reg <= cpu_wdata[7];
            end
            // Error sources and the STATUS clear both need a write strobe,
            // so they can never collide in one cycle.
            if (blocked || bad_op)
                err_reg <= 1'b1;
            else if (wr_status && cpu_wdata[2])
                err_reg <= 1'b0;
            if (cpu_rd)
                cpu_rdata <= rd_mux;
        end
    end

    assign core_start = (state == if_issue_st);
    assign core_op    = e_fpu_operation'(op_reg);
    assign core_a     = a_reg;
    assign core_b     = b_reg;
    assign irq        = IRQ_ON_DONE & ie_reg & done;

endmodule

// File: tb/tb_fpu_bus_if.sv
module tb_fpu_bus_if;
    import pa_fpu::*;

    localparam logic IRQ_EN = 1'b1;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     cpu_addr;
    logic           cpu_wr, cpu_rd;
    logic [7:0]     cpu_wdata;
    logic [7:0]     cpu_rdata;
    logic           irq;
    logic           core_start;
    e_fpu_operation core_op;
    logic [31:0]    core_a, core_b;
    logic           core_done;
    logic [31:0]    core_result;
    logic           core_ack;

    always #5 clk = ~clk;

    fpu_bus_if #(.IRQ_ON_DONE(IRQ_EN)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .irq(irq),
        .core_start(core_start), .core_op(core_op),
        .core_a(core_a), .core_b(core_b),
        .core_done(core_done), .core_result(core_result), .core_ack(core_ack)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model: architectural register contents and flags
    logic [31:0] m_a, m_b, m_res;
    logic [3:0]  m_op;
    logic        m_ie, m_err, m_done, m_busy;
    logic [7:0]  m_rdata;
    logic        exp_start, exp_ack;

    // Core model
    logic        pend;
    int unsigned cnt, lat;
    logic [31:0] core_ret;
    logic        rst_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [3:0] adr);
        logic [7:0] v;
        v = 8'h00;
        if (adr < 4'h4)       v = m_a[8*adr[1:0] +: 8];
        else if (adr < 4'h8)  v = m_b[8*adr[1:0] +: 8];
        else if (adr >= 4'hC) v = m_res[8*adr[1:0] +: 8];
        else if (adr == 4'h8) v = {m_ie, 3'b000, m_op};
        else if (adr == 4'hA) v = {5'b00000, m_err, m_done, m_busy};
        return v;
    endfunction

    // Applies the effect of the coming clock edge to the model using the
    // inputs currently presented to the DUT.
    task automatic model_edge();
        logic was_busy;
        exp_start = 1'b0;
        exp_ack   = 1'b0;
        if (rst) begin
            m_a = '0; m_b = '0; m_res = '0; m_op = '0;
            m_ie = 0; m_err = 0; m_done = 0; m_busy = 0;
            m_rdata = '0;
            rst_seen = 1'b1;
        end else begin
            rst_seen = 1'b0;
            was_busy = m_busy;
            if (cpu_rd) m_rdata = m_read(cpu_addr);
            if (cpu_wr) begin
                if (cpu_addr <= 4'h9 && was_busy) m_err = 1'b1;
                else if (cpu_addr < 4'h4) m_a[8*cpu_addr[1:0] +: 8] = cpu_wdata;
                else if (cpu_addr < 4'h8) m_b[8*cpu_addr[1:0] +: 8] = cpu_wdata;
                else if (cpu_addr == 4'h8) begin
                    m_op = cpu_wdata[3:0];
                    m_ie = cpu_wdata[7];
                end else if (cpu_addr == 4'h9) begin
                    if (m_op <= 4'd11) begin
                        m_busy = 1'b1; m_done = 1'b0; exp_start = 1'b1;
                    end else m_err = 1'b1;
                end else if (cpu_addr == 4'hA) begin
                    if (cpu_wdata[1]) m_done = 1'b0;
                    if (cpu_wdata[2]) m_err = 1'b0;
                end
            end
            // Capture is applied last so it overrides a same-cycle done clear.
            if (was_busy && core_done) begin
                m_res = core_result; m_done = 1'b1; m_busy = 1'b0; exp_ack = 1'b1;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("core_start", core_start, exp_start);
        check("core_ack", core_ack, exp_ack);
        check("irq", irq, IRQ_EN & m_ie & m_done);
        check("core_a", core_a, m_a);
        check("core_b", core_b, m_b);
        check("core_op", 4'(core_op), m_op);
        check("cpu_rdata", cpu_rdata, m_rdata);
        // core behaviour after the edge
        if (rst_seen) begin
            pend = 0; core_done = 0; core_result = $urandom;
        end else begin
            if (core_ack) begin
                core_done = 1'b0; core_result = $urandom;
            end
            if (core_start) begin
                pend = 1'b1; cnt = lat;
            end else if (pend) begin
                if (cnt <= 1) begin
                    core_done = 1'b1; core_result = core_ret; pend = 1'b0;
                end else cnt--;
            end
        end
    endtask

    task automatic bus(input logic [3:0] adr, input logic [7:0] d, input logic w, input logic r);
        cpu_addr = adr; cpu_wdata = d; cpu_wr = w; cpu_rd = r;
        tick();
        cpu_wr = 1'b0; cpu_rd = 1'b0;
    endtask

    task automatic wr(input logic [3:0] adr, input logic [7:0] d);
        bus(adr, d, 1'b1, 1'b0);
    endtask

    task automatic rd_check(input string tag, input logic [3:0] adr, input logic [7:0] exp);
        bus(adr, 8'h00, 1'b0, 1'b1);
        check(tag, cpu_rdata, exp);
    endtask

    task automatic load_ops(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 4; i++) begin
            wr(4'(i), a[8*i +: 8]);
            wr(4'(4 + i), b[8*i +: 8]);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && m_busy; i++) tick();
        check("op_complete", m_busy, 1'b0);
        tick();
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [7:0]  c;
        rst = 1'b1; cpu_addr = '0; cpu_wr = 0; cpu_rd = 0; cpu_wdata = '0;
        core_done = 0; core_result = '0; pend = 0; cnt = 0; lat = 5; core_ret = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("reset_core_a", core_a, 32'h0);
        rd_check("reset_status", 4'hA, 8'h00);

        // Basic add: 1.0 + 2.0 -> 3.0
        lat = 5; core_ret = 32'h40400000;
        load_ops(32'h3F800000, 32'h40000000);
        wr(4'h8, 8'h00);
        wr(4'h9, 8'h00);
        check("issue_start", core_start, 1'b1);
        check("issue_a", core_a, 32'h3F800000);
        check("issue_b", core_b, 32'h40000000);
        wait_done();
        rd_check("add_status", 4'hA, 8'h02);
        rd_check("add_r0", 4'hC, 8'h00);
        rd_check("add_r1", 4'hD, 8'h00);
        rd_check("add_r2", 4'hE, 8'h40);
        rd_check("add_r3", 4'hF, 8'h40);

        // Interrupt with ie set, then cleared via STATUS
        wr(4'h8, 8'h80);
        wr(4'h9, 8'h00);
        wait_done();
        check("irq_set", irq, 1'b1);
        wr(4'hA, 8'h02);
        check("irq_clr", irq, 1'b0);
        rd_check("idle_status", 4'hA, 8'h00);

        // Invalid opcode
        wr(4'h8, 8'h0D);
        wr(4'h9, 8'h00);
        tick();
        check("badop_nostart", core_start, 1'b0);
        rd_check("badop_status", 4'hA, 8'h04);
        wr(4'hA, 8'h04);
        rd_check("err_cleared", 4'hA, 8'h00);

        // Writes while busy are ignored and flag err
        wr(4'h8, 8'h02);
        wr(4'h9, 8'h00);
        tick();
        wr(4'h0, 8'hFF);
        wr(4'h9, 8'h00);
        check("busy_a_kept", core_a, 32'h3F800000);
        wait_done();
        rd_check("busy_err_status", 4'hA, 8'h06);
        wr(4'hA, 8'h06);

        // Reset during an operation
        lat = 8;
        wr(4'h9, 8'h00);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_a", core_a, 32'h0);
        check("rst_op", 4'(core_op), 4'h0);
        for (int i = 0; i < 12; i++) tick();
        rd_check("rst_status", 4'hA, 8'h00);

        // STATUS done-clear coinciding with capture
        lat = 3; core_ret = 32'hCAFE1234;
        load_ops(32'h11223344, 32'h55667788);
        wr(4'h9, 8'h00);
        for (int i = 0; i < 20 && !core_done; i++) tick();
        check("coinc_core_done", core_done, 1'b1);
        wr(4'hA, 8'h02);
        rd_check("coinc_status", 4'hA, 8'h02);
        rd_check("coinc_r0", 4'hC, 8'h34);
        rd_check("coinc_r3", 4'hF, 8'hCA);
        wr(4'hA, 8'h06);

        // Randomized operations with stray accesses
        for (int it = 0; it < 40; it++) begin
            ra = $urandom; rb = $urandom;
            lat = $urandom_range(1, 6); core_ret = $urandom;
            load_ops(ra, rb);
            c = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) c[7] = 1'b1;
            wr(4'h8, c);
            wr(4'h9, 8'($urandom));
            if ($urandom_range(0, 2) == 0)
                bus(4'($urandom_range(0, 15)), 8'($urandom), 1'b1, 1'($urandom_range(0, 1)));
            wait_done();
            bus(4'($urandom_range(0, 15)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            bus(4'hA, 8'h00, 1'b0, 1'b1);
            for (int k = 0; k < 4; k++) bus(4'(12 + k), 8'h00, 1'b0, 1'b1);
            wr(4'hA, 8'($urandom_range(0, 7)));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
